ins_sequencer: RTL and testbench
================================

Name: ins_sequencer

Overview:
- Instruction sequencer that drives the 21-bit instruction bus and the CPU clock strobe of the pin-abstracted CPU core.
- Fetches from instruction ROM at the core's instruction pointer, or accepts host-pushed instructions in manual-load mode.
- Generates the two-phase CPU clock: INS is held stable, CPU_CLK goes high (core captures), then low (core writes back).
- Sits between the ROM/host loader and the CPU core, replacing bench-driven instruction supply.

Parameters:
- ROM_LAT, 1, cycles from the ROM_EN cycle to the cycle ROM_DATA is valid; legal range is 1..7.
- INS_W, 21, instruction width.
- ADDR_W, 8, instruction address width.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle pulse: begin continuous run.
- STEP  in  1  one-cycle pulse: execute exactly one instruction, then return to IDLE.
- STOP  in  1  level: finish the current instruction, then go to IDLE.
- MODE  in  1  instruction source: 0 = ROM fetch, 1 = manual (host) load.
- CPU_ADDR  in  ADDR_W  instruction pointer from the core (Addr).
- ROM_ADDR  out  ADDR_W  ROM read address.
- ROM_EN  out  1  ROM read strobe.
- ROM_DATA  in  INS_W  ROM read data.
- HOST_INS  in  INS_W  manual instruction.
- HOST_VALID  in  1  manual instruction valid.
- HOST_READY  out  1  sequencer ready to accept a manual instruction.
- INS  out  INS_W  instruction bus to the core.
- CPU_CLK  out  1  core clock strobe.
- BUSY  out  1  high in every state except IDLE and HALTED.
- HALTED  out  1  high while in HALTED.
- ICOUNT  out  16  count of issued instructions.

Behaviour:
- Reset (asynchronous, immediate): state = IDLE; INS = 0, CPU_CLK = 0, ROM_EN = 0, ROM_ADDR = 0, HOST_READY = 0, BUSY = 0, HALTED = 0, ICOUNT = 0. Reset mid-instruction drops CPU_CLK in the same instant and abandons that instruction.
- States: IDLE, FETCH, WAIT, HOSTW, CLK_HI, CLK_LO, HALTED.
- IDLE:
  - STOP high: stay in IDLE, even if START or STEP is also high.
  - Otherwise START or STEP: latch the step flag (STEP has priority over START), latch MODE, then go to FETCH (MODE = 0) or HOSTW (MODE = 1).
  - MODE is sampled only on IDLE exit; changing it mid-run has no effect.
- FETCH (1 cycle): ROM_EN = 1, ROM_ADDR = CPU_ADDR, then WAIT. ROM_EN is 0 in every other state.
- WAIT: stays ROM_LAT cycles. On the last cycle, capture ROM_DATA into the instruction register.
  - Captured word all zeros (HALT): go to HALTED with no CPU_CLK pulse and no ICOUNT change.
  - Otherwise: go to CLK_HI.
- HOSTW: HOST_READY = 1. On HOST_VALID && HOST_READY, capture HOST_INS and apply the same HALT check as WAIT. STOP while in HOSTW (no handshake yet) goes to IDLE.
- CLK_HI (1 cycle): CPU_CLK = 1; ICOUNT += 1, saturating at 0xFFFF.
- CLK_LO (1 cycle): CPU_CLK = 0, so the core updates Addr. Next state:
  - IDLE if STOP is high or the step flag is set;
  - otherwise FETCH (MODE = 0) or HOSTW (MODE = 1).
- INS changes only on capture. It holds its value through CLK_HI, CLK_LO and IDLE.
- ROM-mode period is ROM_LAT + 3 cycles per instruction (4 with the default).
- Manual-mode period is 3 cycles when HOST_VALID is held high.
- HALTED: only RST or a START pulse leaves it; START goes to IDLE and clears HALTED. STEP and STOP are ignored.
- START or STEP while BUSY is ignored.

Optional Feature:
- Macro: INS_SEQ_BREAKPOINT_EN.
- When defined:
  - Adds inputs BP_ADDR [ADDR_W] and BP_ARM [1], and output BP_HIT [1].
  - On entry to FETCH, if BP_ARM && CPU_ADDR == BP_ADDR, go to IDLE instead with no ROM_EN, and set BP_HIT = 1.
  - The check is skipped on the first FETCH after leaving IDLE, so execution can resume from the breakpoint.
  - BP_HIT clears on the next START or STEP; reset value is 0.
- When undefined: these ports do not exist and no address compare is performed.

Test Plan:
- Reset then START, MODE = 0, ROM = {0: 0x0C0005, 1: 0x0C0107, 2: 0x000000}, core advances Addr → two CPU_CLK pulses 4 cycles apart, INS shows 0x0C0005 then 0x0C0107, then HALTED = 1, ICOUNT = 2.
- ROM_LAT = 3: same program → CPU_CLK pulses 6 cycles apart; ROM_EN high exactly 1 cycle per fetch.
- STEP, MODE = 1, HOST_VALID raised 2 cycles late with 0x1C0001 → HOST_READY high 3 cycles, one CPU_CLK pulse, return to IDLE, ICOUNT = 1.
- START + STOP in the same IDLE cycle → stays IDLE, no ROM_EN. STOP raised during WAIT → current instruction completes its CLK_HI/CLK_LO, then IDLE.
- RST asserted during CLK_HI → CPU_CLK and all outputs are 0 immediately; START afterwards refetches at CPU_ADDR.
- INS_SEQ_BREAKPOINT_EN, BP_ADDR = 1, BP_ARM = 1 → stops before fetching address 1 with BP_HIT = 1; the next START executes address 1 normally.

Source files
------------

// File: rtl/ins_sequencer_if.sv
// Sequencer bus bundle: run control, ROM port, host load port and CPU-side outputs.
// Optional breakpoint signals exist only when INS_SEQ_BREAKPOINT_EN is defined.
interface ins_sequencer_if #(
  parameter int INS_W  = 21,
  parameter int ADDR_W = 8
);
  logic              START;
  logic              STEP;
  logic              STOP;
  logic              MODE;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic [ADDR_W-1:0] ROM_ADDR;
  logic              ROM_EN;
  logic [INS_W-1:0]  ROM_DATA;
  logic [INS_W-1:0]  HOST_INS;
  logic              HOST_VALID;
  logic              HOST_READY;
  logic [INS_W-1:0]  INS;
  logic              CPU_CLK;
  logic              BUSY;
  logic              HALTED;
  logic [15:0]       ICOUNT;
`ifdef INS_SEQ_BREAKPOINT_EN
  logic [ADDR_W-1:0] BP_ADDR;
  logic              BP_ARM;
  logic              BP_HIT;
`endif

  modport master (
    input  START, STEP, STOP, MODE, CPU_ADDR, ROM_DATA, HOST_INS, HOST_VALID,
    output ROM_ADDR, ROM_EN, HOST_READY, INS, CPU_CLK, BUSY, HALTED, ICOUNT
`ifdef INS_SEQ_BREAKPOINT_EN
    , input BP_ADDR, BP_ARM
    , output BP_HIT
`endif
  );

  modport slave (
    output START, STEP, STOP, MODE, CPU_ADDR, ROM_DATA, HOST_INS, HOST_VALID,
    input  ROM_ADDR, ROM_EN, HOST_READY, INS, CPU_CLK, BUSY, HALTED, ICOUNT
`ifdef INS_SEQ_BREAKPOINT_EN
    , output BP_ADDR, BP_ARM
    , input BP_HIT
`endif
  );
endinterface

// File: rtl/ins_sequencer.sv
// Instruction sequencer: ROM fetch or host load, then a two-phase CPU_CLK strobe; breakpoints under INS_SEQ_BREAKPOINT_EN.
// Period ROM_LAT+3 cycles (ROM) or 3 cycles (host, VALID held); HOST_READY only while waiting in HOSTW, ROM never stalls.
module ins_sequencer #(
  parameter int ROM_LAT = 1,
  parameter int INS_W   = 21,
  parameter int ADDR_W  = 8
) (
  input logic            CLK,
  input logic            RST,
  ins_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_HOSTW, S_CLK_HI, S_CLK_LO, S_HALTED
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(ROM_LAT - 1);

  state_t           state, state_n;
  logic [INS_W-1:0] ins;
  logic [INS_W-1:0] cap_dat;
  logic             cap_en;
  logic             launch;
  logic             step_flag;
  logic             mode_r;
  logic [2:0]       wait_cnt;
  logic [15:0]      icount;
`ifdef INS_SEQ_BREAKPOINT_EN
  logic             bp_set;
  logic             bp_hit;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    cap_en  = 1'b0;
    cap_dat = bus.ROM_DATA;
    launch  = 1'b0;
`ifdef INS_SEQ_BREAKPOINT_EN
    bp_set  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!bus.STOP && (bus.START || bus.STEP)) begin
          launch  = 1'b1;
          state_n = bus.MODE ? S_HOSTW : S_FETCH;
        end
      end
      S_FETCH: state_n = S_WAIT;
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          cap_en  = 1'b1;
          state_n = (bus.ROM_DATA == '0) ? S_HALTED : S_CLK_HI;
        end
      end
      S_HOSTW: begin
        // A completed handshake wins over a concurrent STOP.
        if (bus.HOST_VALID) begin
          cap_en  = 1'b1;
          cap_dat = bus.HOST_INS;
          state_n = (bus.HOST_INS == '0) ? S_HALTED : S_CLK_HI;
        end else if (bus.STOP) begin
          state_n = S_IDLE;
        end
      end
      S_CLK_HI: state_n = S_CLK_LO;
      S_CLK_LO: begin
        if (bus.STOP || step_flag) begin
          state_n = S_IDLE;
        end else if (mode_r) begin
          state_n = S_HOSTW;
        end else begin
`ifdef INS_SEQ_BREAKPOINT_EN
          // Only fetches following an instruction are checked, so a run resumes at the breakpoint.
          if (bus.BP_ARM && (bus.CPU_ADDR == bus.BP_ADDR)) begin
            bp_set  = 1'b1;
            state_n = S_IDLE;
          end else begin
            state_n = S_FETCH;
          end
`else
          state_n = S_FETCH;
`endif
        end
      end
      S_HALTED: begin
        if (bus.START) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ins       <= '0;
      icount    <= '0;
      step_flag <= 1'b0;
      mode_r    <= 1'b0;
      wait_cnt  <= '0;
`ifdef INS_SEQ_BREAKPOINT_EN
      bp_hit    <= 1'b0;
`endif
    end else begin
      if (cap_en) ins <= cap_dat;
      if (launch) begin
        step_flag <= bus.STEP;
        mode_r    <= bus.MODE;
      end
      if (state == S_FETCH)     wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 3'd1;
      if (state == S_CLK_HI && icount != 16'hFFFF) icount <= icount + 16'd1;
`ifdef INS_SEQ_BREAKPOINT_EN
      if (launch)      bp_hit <= 1'b0;
      else if (bp_set) bp_hit <= 1'b1;
`endif
    end
  end

  // Strobes decode straight from state so reset drops them immediately.
  assign bus.INS        = ins;
  assign bus.CPU_CLK    = (state == S_CLK_HI);
  assign bus.ROM_EN     = (state == S_FETCH);
  assign bus.ROM_ADDR   = (state == S_FETCH) ? bus.CPU_ADDR : '0;
  assign bus.HOST_READY = (state == S_HOSTW);
  assign bus.BUSY       = (state != S_IDLE) && (state != S_HALTED);
  assign bus.HALTED     = (state == S_HALTED);
  assign bus.ICOUNT     = icount;
`ifdef INS_SEQ_BREAKPOINT_EN
  assign bus.BP_HIT     = bp_hit;
`endif

endmodule

// File: tb/tb_ins_sequencer.sv
// Directed bench: one sequencer at ROM_LAT=1 (dut_a) and one at ROM_LAT=3 (dut_b), each with a ROM and a core model.
module tb_ins_sequencer;

  logic clk;
  logic rst;
  logic core_clr;
  int   errors;
  int   checks;

  ins_sequencer_if #(.INS_W(21), .ADDR_W(8)) ba ();
  ins_sequencer_if #(.INS_W(21), .ADDR_W(8)) bb ();

  ins_sequencer #(.ROM_LAT(1), .INS_W(21), .ADDR_W(8)) dut_a (.CLK(clk), .RST(rst), .bus(ba));
  ins_sequencer #(.ROM_LAT(3), .INS_W(21), .ADDR_W(8)) dut_b (.CLK(clk), .RST(rst), .bus(bb));

  logic [20:0] rom [0:255];
  logic [20:0] ra_q, rb0, rb1, rb2;
  logic [7:0]  addr_a, addr_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM models: data valid ROM_LAT cycles after the enable cycle.
  always @(posedge clk) if (ba.ROM_EN) ra_q <= rom[ba.ROM_ADDR];
  always @(posedge clk) begin
    if (bb.ROM_EN) rb0 <= rom[bb.ROM_ADDR];
    rb1 <= rb0;
    rb2 <= rb1;
  end
  assign ba.ROM_DATA = ra_q;
  assign bb.ROM_DATA = rb2;

  // Core models: instruction pointer advances on the falling CPU_CLK edge.
  always @(negedge ba.CPU_CLK or posedge core_clr)
    if (core_clr) addr_a <= '0;
    else if (!rst) addr_a <= addr_a + 8'd1;
  always @(negedge bb.CPU_CLK or posedge core_clr)
    if (core_clr) addr_b <= '0;
    else if (!rst) addr_b <= addr_b + 8'd1;
  assign ba.CPU_ADDR = addr_a;
  assign bb.CPU_ADDR = addr_b;

  int cyc, en_a, en_b, hr_a, pa_n, pb_n, pa_t, pa_tp, pb_t, pb_tp;
  logic [20:0] pa_i, pa_ip;
  always @(negedge clk) begin
    cyc++;
    if (ba.ROM_EN) en_a++;
    if (bb.ROM_EN) en_b++;
    if (ba.HOST_READY) hr_a++;
    if (ba.CPU_CLK) begin pa_n++; pa_tp = pa_t; pa_t = cyc; pa_ip = pa_i; pa_i = ba.INS; end
    if (bb.CPU_CLK) begin pb_n++; pb_tp = pb_t; pb_t = cyc; end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_core();
    core_clr = 1'b1;
    #1;
    core_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clr_core();
  endtask

  int e0, h0, p0, seen;

  initial begin
    errors = 0; checks = 0; core_clr = 1'b0;
    cyc = 0; en_a = 0; en_b = 0; hr_a = 0; pa_n = 0; pb_n = 0;
    pa_t = 0; pa_tp = 0; pb_t = 0; pb_tp = 0; pa_i = '0; pa_ip = '0;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0] = 21'h0C0005;
    rom[1] = 21'h0C0107;
    rst = 1'b1;
    ba.START = 0; ba.STEP = 0; ba.STOP = 0; ba.MODE = 0; ba.HOST_INS = '0; ba.HOST_VALID = 0;
    bb.START = 0; bb.STEP = 0; bb.STOP = 0; bb.MODE = 0; bb.HOST_INS = '0; bb.HOST_VALID = 0;
`ifdef INS_SEQ_BREAKPOINT_EN
    ba.BP_ADDR = '0; ba.BP_ARM = 0; bb.BP_ADDR = '0; bb.BP_ARM = 0;
`endif
    tick();
    clr_core();
    tick();

    // Reset state
    chk("rst_ins", 32'(ba.INS), 0);
    chk("rst_cpu_clk", 32'(ba.CPU_CLK), 0);
    chk("rst_rom_en", 32'(ba.ROM_EN), 0);
    chk("rst_rom_addr", 32'(ba.ROM_ADDR), 0);
    chk("rst_host_ready", 32'(ba.HOST_READY), 0);
    chk("rst_busy_halted", {30'd0, ba.BUSY, ba.HALTED}, 0);
    chk("rst_icount", 32'(ba.ICOUNT), 0);
    rst = 1'b0;
    tick();

    // ROM program on both latencies
    ba.START = 1; bb.START = 1;
    tick();
    ba.START = 0; bb.START = 0;
    for (int i = 0; i < 40; i++) begin
      if (ba.HALTED && bb.HALTED) break;
      tick();
    end
    chk("run_a_halted", 32'(ba.HALTED), 1);
    chk("run_a_icount", 32'(ba.ICOUNT), 2);
    chk("run_a_pulses", 32'(pa_n), 2);
    chk("run_a_period", 32'(pa_t - pa_tp), 4);
    chk("run_a_ins0", 32'(pa_ip), 32'h0C0005);
    chk("run_a_ins1", 32'(pa_i), 32'h0C0107);
    chk("run_a_rom_en", 32'(en_a), 3);
    chk("run_a_busy", 32'(ba.BUSY), 0);
    chk("run_b_halted", 32'(bb.HALTED), 1);
    chk("run_b_icount", 32'(bb.ICOUNT), 2);
    chk("run_b_period", 32'(pb_t - pb_tp), 6);
    chk("run_b_rom_en", 32'(en_b), 3);

    // HALTED ignores STEP, leaves on START
    ba.STEP = 1; tick(); ba.STEP = 0; tick();
    chk("halt_step_ignored", {30'd0, ba.HALTED, ba.BUSY}, 32'h2);
    ba.START = 1; tick(); ba.START = 0; tick();
    chk("halt_start_exit", {30'd0, ba.HALTED, ba.BUSY}, 0);

    // Manual STEP, HOST_VALID two cycles late
    do_reset();
    tick();
    h0 = hr_a; p0 = pa_n;
    ba.MODE = 1; ba.STEP = 1; tick();
    ba.STEP = 0; ba.MODE = 0; tick();
    tick();
    ba.HOST_INS = 21'h1C0001; ba.HOST_VALID = 1; tick();
    ba.HOST_VALID = 0; ba.HOST_INS = '0;
    chk("man_cpu_clk", 32'(ba.CPU_CLK), 1);
    chk("man_ins", 32'(ba.INS), 32'h1C0001);
    tick(); tick(); tick();
    chk("man_idle", {30'd0, ba.BUSY, ba.HOST_READY}, 0);
    chk("man_ready_cycles", 32'(hr_a - h0), 3);
    chk("man_pulses", 32'(pa_n - p0), 1);
    chk("man_icount", 32'(ba.ICOUNT), 1);

    // START with STOP in IDLE
    e0 = en_a;
    ba.START = 1; ba.STOP = 1; tick();
    ba.START = 0; tick(); tick();
    chk("startstop_busy", 32'(ba.BUSY), 0);
    chk("startstop_no_fetch", 32'(en_a - e0), 0);
    ba.STOP = 0;

    // STOP during WAIT completes the instruction
    clr_core();
    e0 = en_b; p0 = pb_n;
    bb.START = 1; tick();
    bb.START = 0; tick();
    bb.STOP = 1;
    for (int i = 0; i < 8; i++) tick();
    chk("stopwait_pulses", 32'(pb_n - p0), 1);
    chk("stopwait_busy", 32'(bb.BUSY), 0);
    chk("stopwait_icount", 32'(bb.ICOUNT), 1);
    chk("stopwait_ins", 32'(bb.INS), 32'h0C0005);
    chk("stopwait_fetches", 32'(en_b - e0), 1);
    bb.STOP = 0;

    // Reset during CLK_HI, then refetch
    clr_core();
    ba.START = 1; tick();
    ba.START = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ba.CPU_CLK) begin
        seen++;
        if (seen == 2) break;
      end
    end
    chk("rsthi_second_pulse", 32'(seen), 2);
    rst = 1'b1;
    #1;
    chk("rsthi_cpu_clk", 32'(ba.CPU_CLK), 0);
    chk("rsthi_outputs", {ba.ICOUNT, 11'd0, ba.BUSY, ba.HALTED, ba.ROM_EN, ba.HOST_READY, ba.INS == '0}, 1);
    chk("rsthi_core_addr", 32'(addr_a), 1);
    tick();
    rst = 1'b0;
    tick();
    ba.START = 1; tick();
    ba.START = 0;
    chk("refetch_rom_en", 32'(ba.ROM_EN), 1);
    chk("refetch_addr", 32'(ba.ROM_ADDR), 1);
    for (int i = 0; i < 20; i++) begin
      if (ba.HALTED) break;
      tick();
    end
    chk("refetch_halted_icount", {15'd0, ba.HALTED, ba.ICOUNT}, 32'h10001);

`ifdef INS_SEQ_BREAKPOINT_EN
    // Breakpoint at address 1, then resume through it
    do_reset();
    ba.BP_ADDR = 8'd1; ba.BP_ARM = 1;
    e0 = en_a;
    ba.START = 1; tick();
    ba.START = 0; tick();
    for (int i = 0; i < 20; i++) begin
      if (!ba.BUSY) break;
      tick();
    end
    chk("bp_hit", 32'(ba.BP_HIT), 1);
    chk("bp_icount", 32'(ba.ICOUNT), 1);
    chk("bp_addr", 32'(addr_a), 1);
    chk("bp_fetches", 32'(en_a - e0), 1);
    chk("bp_not_halted", 32'(ba.HALTED), 0);
    ba.START = 1; tick();
    ba.START = 0;
    chk("bp_clear", 32'(ba.BP_HIT), 0);
    for (int i = 0; i < 20; i++) begin
      if (ba.HALTED) break;
      tick();
    end
    chk("bp_resume_halted", 32'(ba.HALTED), 1);
    chk("bp_resume_icount", 32'(ba.ICOUNT), 2);
    chk("bp_resume_ins", 32'(pa_i), 32'h0C0107);
    ba.BP_ARM = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
